// File: rtl/acc_pkg.sv
// acc_pkg: arbiter state encoding and default memory widths shared by the
// accelerator memory arbiter and its bench.
package acc_pkg;
    localparam int ADDR_SIZE       = 16;
    localparam int READ_DATA_SIZE  = 512;
    localparam int WRITE_DATA_SIZE = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ISSUE,
        READ_WAIT,
        READ_RESP
    } arb_state_t;
endpackage

// File: rtl/acc_rr_picker.sv
// acc_rr_picker: combinational round-robin choice of one requesting port,
// searching upward from the port after last_grant_i and wrapping.
module acc_rr_picker #(
    parameter int NUM_ACC = 4,
    parameter int IW      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic [NUM_ACC-1:0] req_i,
    input  logic [IW-1:0]      last_grant_i,
    output logic               grant_valid_o,
    output logic [IW-1:0]      grant_idx_o
);
    logic [IW-1:0] idx;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = '0;
        for (int k = 1; k <= NUM_ACC; k++) begin
            idx = IW'((int'(last_grant_i) + k) % NUM_ACC);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end
endmodule

// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter: shares one memory port among NUM_ACC accelerators, one
// operation at a time, round-robin, with CPU ownership blocking new grants.
module acc_mem_arbiter #(
    parameter int NUM_ACC          = 4,
    parameter int ADDR_SIZE        = acc_pkg::ADDR_SIZE,
    parameter int READ_DATA_SIZE   = acc_pkg::READ_DATA_SIZE,
    parameter int WRITE_DATA_SIZE  = acc_pkg::WRITE_DATA_SIZE,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_ACC-1:0]                 acc_read_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]       acc_read_addr,
    input  logic [NUM_ACC-1:0]                 acc_write_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]       acc_write_addr,
    input  logic [NUM_ACC*WRITE_DATA_SIZE-1:0] acc_write_data,
    output logic [NUM_ACC-1:0]                 acc_read_data_valid,
    output logic [READ_DATA_SIZE-1:0]          acc_read_data,
    output logic [NUM_ACC-1:0]                 acc_write_done,
    input  logic                               cpu_mem_busy,
    output logic                               mem_read_en,
    output logic [ADDR_SIZE-1:0]               mem_read_addr,
    input  logic [READ_DATA_SIZE-1:0]          mem_read_data,
    output logic                               mem_write_en,
    output logic [ADDR_SIZE-1:0]               mem_write_addr,
    output logic [WRITE_DATA_SIZE-1:0]         mem_write_data
);
    import acc_pkg::arb_state_t, acc_pkg::IDLE, acc_pkg::WRITE,
           acc_pkg::READ_ISSUE, acc_pkg::READ_WAIT, acc_pkg::READ_RESP;

    localparam int IW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int CW = $clog2(MEM_READ_LATENCY + 1);

    arb_state_t                 state_q, state_d;
    logic [IW-1:0]              gnt_q, gnt_d, last_q, last_d;
    logic [ADDR_SIZE-1:0]       addr_q, addr_d;
    logic [WRITE_DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [READ_DATA_SIZE-1:0]  rdata_q, rdata_d;
    logic                       pick_valid;
    logic [IW-1:0]              pick_idx;
    logic [NUM_ACC-1:0]         gnt_onehot;

    acc_rr_picker #(.NUM_ACC(NUM_ACC), .IW(IW)) u_picker (
        .req_i         (acc_read_en | acc_write_en),
        .last_grant_i  (last_q),
        .grant_valid_o (pick_valid),
        .grant_idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // a port asking for both gets its read first; the write stays pending
                if (!cpu_mem_busy && pick_valid) begin
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    state_d = acc_read_en[pick_idx] ? READ_ISSUE : WRITE;
                    addr_d  = acc_read_en[pick_idx] ? acc_read_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE]
                                                    : acc_write_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
                    wdata_d = acc_write_data[pick_idx*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
                end
            end
            WRITE:      state_d = IDLE;
            READ_ISSUE: begin
                state_d = READ_WAIT;
                cnt_d   = CW'(MEM_READ_LATENCY - 1);
            end
            READ_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = READ_RESP;
                    rdata_d = mem_read_data;
                end
            end
            READ_RESP:  state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_ACC - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign gnt_onehot          = NUM_ACC'(1) << gnt_q;
    assign mem_write_en        = state_q == WRITE;
    assign mem_write_addr      = mem_write_en ? addr_q : '0;
    assign mem_write_data      = mem_write_en ? wdata_q : '0;
    assign mem_read_en         = state_q == READ_ISSUE;
    assign mem_read_addr       = mem_read_en ? addr_q : '0;
    assign acc_write_done      = mem_write_en ? gnt_onehot : '0;
    assign acc_read_data_valid = (state_q == READ_RESP) ? gnt_onehot : '0;
    assign acc_read_data       = rdata_q;
endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb_acc_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-timeline model of the arbiter.
module tb_acc_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int RW = 512;
    localparam int WW = 32;
    localparam int L  = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    acc_read_en, acc_write_en;
    logic [N*AW-1:0] acc_read_addr, acc_write_addr;
    logic [N*WW-1:0] acc_write_data;
    logic [N-1:0]    acc_read_data_valid, acc_write_done;
    logic [RW-1:0]   acc_read_data;
    logic            cpu_mem_busy;
    logic            mem_read_en, mem_write_en;
    logic [AW-1:0]   mem_read_addr, mem_write_addr;
    logic [RW-1:0]   mem_read_data;
    logic [WW-1:0]   mem_write_data;

    int vectors = 0;
    int miscompares = 0;
    bit run = 1'b0;

    acc_mem_arbiter #(
        .NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW),
        .WRITE_DATA_SIZE(WW), .MEM_READ_LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .acc_read_en(acc_read_en), .acc_read_addr(acc_read_addr),
        .acc_write_en(acc_write_en), .acc_write_addr(acc_write_addr),
        .acc_write_data(acc_write_data),
        .acc_read_data_valid(acc_read_data_valid), .acc_read_data(acc_read_data),
        .acc_write_done(acc_write_done), .cpu_mem_busy(cpu_mem_busy),
        .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] pat(input logic [AW-1:0] a);
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = {a ^ AW'(i * 16'h1111), ~a};
        return r;
    endfunction

    // memory returns the addressed line L=1 cycle after the command, junk otherwise
    always @(posedge clk) mem_read_data <= mem_read_en ? pat(mem_read_addr) : {16{$urandom}};

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // model: one operation in flight, described by kind, port and grant cycle
    int            cyc = 0, t0 = 0, d, op_kind = 0, op_port = 0, last = N - 1, gp = 0;
    logic [AW-1:0] op_addr;
    logic [WW-1:0] op_data;
    logic [RW-1:0] exp_rdata = '0;
    logic [N-1:0]  e_done, e_valid, pv_rd = '0, pv_wr = '0;
    logic          e_wen, e_ren, gv = 1'b0, g_rd = 1'b0;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [WW-1:0] e_wdata;

    always @(negedge clk) if (run) begin
        e_done = '0; e_valid = '0; e_wen = 1'b0; e_ren = 1'b0;
        e_waddr = '0; e_raddr = '0; e_wdata = '0;
        d = cyc - t0;
        if (op_kind == 1 && d == 1) begin
            e_wen = 1'b1; e_waddr = op_addr; e_wdata = op_data; e_done = N'(1) << op_port;
        end
        if (op_kind == 2 && d == 1) begin
            e_ren = 1'b1; e_raddr = op_addr;
        end
        if (op_kind == 2 && d == 2 + L) begin
            e_valid = N'(1) << op_port; exp_rdata = pat(op_addr);
        end
        chk("mem_write_en", RW'(mem_write_en), RW'(e_wen));
        chk("mem_write_addr", RW'(mem_write_addr), RW'(e_waddr));
        chk("mem_write_data", RW'(mem_write_data), RW'(e_wdata));
        chk("mem_read_en", RW'(mem_read_en), RW'(e_ren));
        chk("mem_read_addr", RW'(mem_read_addr), RW'(e_raddr));
        chk("acc_write_done", RW'(acc_write_done), RW'(e_done));
        chk("acc_read_data_valid", RW'(acc_read_data_valid), RW'(e_valid));
        chk("acc_read_data", acc_read_data, exp_rdata);
        pv_wr = e_done; pv_rd = e_valid; gv = 1'b0;
        if (!rst_n) begin
            op_kind = 0; last = N - 1; exp_rdata = '0;
        end else begin
            if ((op_kind == 1 && d >= 2) || (op_kind == 2 && d >= 3 + L)) op_kind = 0;
            if (op_kind == 0 && !cpu_mem_busy)
                for (int k = 1; k <= N; k++) begin
                    int p;
                    p = (last + k) % N;
                    if (!gv && (acc_read_en[p] || acc_write_en[p])) begin
                        gv = 1'b1; gp = p; g_rd = acc_read_en[p];
                    end
                end
            if (gv) begin
                last = gp; op_port = gp; t0 = cyc; op_kind = g_rd ? 2 : 1;
                op_addr = g_rd ? acc_read_addr[gp*AW +: AW] : acc_write_addr[gp*AW +: AW];
                op_data = acc_write_data[gp*WW +: WW];
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        acc_read_en = '0; acc_write_en = '0; acc_read_addr = '0;
        acc_write_addr = '0; acc_write_data = '0; cpu_mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [N-1:0] rr_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    logic [N-1:0] infl = '0;

    initial begin
        clear_inputs();
        step();
        run = 1'b1;
        do_reset();
        chk("reset_outputs", RW'({mem_read_en, mem_write_en, acc_write_done,
                                  acc_read_data_valid, mem_read_addr, mem_write_addr}), RW'(0));
        chk("reset_rdata", acc_read_data, RW'(0));

        // single write on port 1
        acc_write_en[1] = 1'b1; acc_write_addr[1*AW +: AW] = 16'h5000; acc_write_data[1*WW +: WW] = 32'h5;
        step();
        chk("wr_en_c1", RW'(mem_write_en), RW'(1));
        chk("wr_addr_c1", RW'(mem_write_addr), RW'(16'h5000));
        chk("wr_data_c1", RW'(mem_write_data), RW'(32'h5));
        chk("wr_done_c1", RW'(acc_write_done), RW'(4'b0010));
        acc_write_en = '0;
        step();
        chk("wr_done_c2", RW'(acc_write_done), RW'(0));

        // single read on port 2
        acc_read_en[2] = 1'b1; acc_read_addr[2*AW +: AW] = 16'h1000;
        step();
        chk("rd_en_c1", RW'(mem_read_en), RW'(1));
        chk("rd_addr_c1", RW'(mem_read_addr), RW'(16'h1000));
        acc_read_en = '0;
        step();
        step();
        chk("rd_valid_c3", RW'(acc_read_data_valid), RW'(4'b0100));
        chk("rd_data_c3", acc_read_data, pat(16'h1000));
        step();
        step();
        chk("rd_valid_c5", RW'(acc_read_data_valid), RW'(0));
        chk("rd_data_held", acc_read_data, pat(16'h1000));

        // reset while waiting on memory drops the read
        acc_read_en[2] = 1'b1; acc_read_addr[2*AW +: AW] = 16'h2222;
        step();
        step();
        rst_n = 1'b0;
        clear_inputs();
        step();
        chk("abort_outputs", RW'({mem_read_en, mem_write_en, acc_write_done, acc_read_data_valid}), RW'(0));
        chk("abort_rdata", acc_read_data, RW'(0));
        rst_n = 1'b1;
        acc_write_en = 4'b1001;
        step();
        chk("abort_valid", RW'(acc_read_data_valid), RW'(0));
        chk("abort_first_grant", RW'(acc_write_done), RW'(4'b0001));
        clear_inputs();
        step();
        step();

        // all ports write continuously: rotation 0,1,2,3,0
        do_reset();
        acc_write_en = '1;
        for (int p = 0; p < N; p++) acc_write_addr[p*AW +: AW] = AW'(16'h0100 * p);
        for (int c = 0; c < 9; c++) begin
            step();
            chk($sformatf("rr_done_c%0d", c + 1), RW'(acc_write_done), RW'(rr_seq[c]));
        end
        clear_inputs();
        step();
        step();

        // CPU holds memory for 5 cycles
        do_reset();
        cpu_mem_busy = 1'b1; acc_write_en[0] = 1'b1; acc_write_addr[0 +: AW] = 16'h0abc;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("busy_quiet_c%0d", c), RW'({mem_read_en, mem_write_en}), RW'(0));
            step();
        end
        cpu_mem_busy = 1'b0;
        chk("busy_quiet_c5", RW'({mem_read_en, mem_write_en}), RW'(0));
        step();
        chk("busy_grant_en", RW'(mem_write_en), RW'(1));
        chk("busy_grant_done", RW'(acc_write_done), RW'(4'b0001));
        clear_inputs();
        step();

        // port 3 reads and writes together: read first
        do_reset();
        acc_read_en[3] = 1'b1; acc_read_addr[3*AW +: AW] = 16'h3333;
        acc_write_en[3] = 1'b1; acc_write_addr[3*AW +: AW] = 16'h4444;
        step();
        chk("both_rd_first", RW'({mem_read_en, mem_write_en}), RW'(2'b10));
        step();
        step();
        chk("both_rd_valid", RW'(acc_read_data_valid), RW'(4'b1000));
        acc_read_en = '0;
        step();
        step();
        chk("both_wr_en", RW'({mem_read_en, mem_write_en}), RW'(2'b01));
        chk("both_wr_done", RW'(acc_write_done), RW'(4'b1000));
        chk("both_wr_addr", RW'(mem_write_addr), RW'(16'h4444));
        clear_inputs();
        step();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cpu_mem_busy = ($urandom_range(0, 9) == 0);
            if (!rst_n) begin
                clear_inputs();
                infl = '0;
            end else begin
                for (int p = 0; p < N; p++) begin
                    if (pv_rd[p]) begin acc_read_en[p] = 1'b0; infl[p] = 1'b0; end
                    if (pv_wr[p]) begin acc_write_en[p] = 1'b0; infl[p] = 1'b0; end
                    if (gv && gp == p) begin
                        infl[p] = 1'b1;
                        if ($urandom_range(0, 3) == 0) begin
                            if (g_rd) acc_read_en[p] = 1'b0;
                            else acc_write_en[p] = 1'b0;
                        end
                    end
                    if (!infl[p] && !acc_read_en[p] && $urandom_range(0, 2) == 0) begin
                        acc_read_en[p] = 1'b1;
                        acc_read_addr[p*AW +: AW] = AW'($urandom);
                    end
                    if (!infl[p] && !acc_write_en[p] && $urandom_range(0, 2) == 0) begin
                        acc_write_en[p] = 1'b1;
                        acc_write_addr[p*AW +: AW] = AW'($urandom);
                        acc_write_data[p*WW +: WW] = $urandom;
                    end
                end
            end
            step();
        end
        rst_n = 1'b1;
        clear_inputs();
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
